// File: rtl/kirsch_window_gen.sv
// 3x3 sliding-window generator for raster-scanned 8-bit pixels, feeding a Kirsch edge operator.
// Optional build macro KWIN_FRAME_DONE_EN adds a frame_done pulse on the last pixel of each frame.
module kirsch_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] p4,
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8,
  output logic [7:0] p9,
`ifdef KWIN_FRAME_DONE_EN
  output logic       frame_done,
`endif
  output logic       win_valid
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    line1 [IMG_W];
  logic [7:0]    line2 [IMG_W];
  logic [7:0]    up1_pix;
  logic [7:0]    up2_pix;
  logic          col_last;
  logic          row_last;
  logic          interior;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign interior = (row >= ROW_TWO) && (col >= COL_TWO);
  assign up1_pix  = line1[col];
  assign up2_pix  = line2[col];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers are never cleared: rows 0 and 1 of every frame overwrite
  // every column before any window with row>=2 is exposed.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line1[col] <= pix_in;
      line2[col] <= up1_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0; p2 <= '0; p3 <= '0;
      p4 <= '0; p5 <= '0; p6 <= '0;
      p7 <= '0; p8 <= '0; p9 <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= pix_valid && interior;
      if (pix_valid) begin
        p1 <= p2; p2 <= p3; p3 <= up2_pix;
        p4 <= p5; p5 <= p6; p6 <= up1_pix;
        p7 <= p8; p8 <= p9; p9 <= pix_in;
      end
    end
  end

`ifdef KWIN_FRAME_DONE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pix_valid && row_last && col_last;
    end
  end
`endif

endmodule

// File: tb/tb_kirsch_window_gen.sv
// Directed bench for kirsch_window_gen on a 4x4 image: ramps, gapped input, mid-frame reset, back-to-back frames.
// frame_done is connected and checked only when KWIN_FRAME_DONE_EN is defined.
module tb_kirsch_window_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       win_valid;
`ifdef KWIN_FRAME_DONE_EN
  logic       frame_done;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          pix_idx;
    logic [71:0] win;
  } win_rec_t;

  win_rec_t tab [4];

  kirsch_window_gen #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5),
    .p6(p6), .p7(p7), .p8(p8), .p9(p9),
`ifdef KWIN_FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .win_valid(win_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] mkwin(input int a, b, c, d, e, f, g, h, i);
    mkwin = {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  function automatic logic [71:0] offset_win(input logic [71:0] w, input int base);
    logic [71:0] r;
    for (int j = 0; j < 9; j++) r[j*8 +: 8] = w[j*8 +: 8] + 8'(base);
    offset_win = r;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic v);
    @(negedge clk);
    pix_in    = d;
    pix_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Streams one 4x4 ramp frame base..base+15, optionally with an idle cycle after each pixel.
  task automatic stream_frame(input int base, input bit gap, input string tag);
    int k = 0;
    int seen = 0;
    for (int idx = 0; idx < 16; idx++) begin
      logic exp_wv;
      exp_wv = ((idx / 4) >= 2) && ((idx % 4) >= 2);
      send(8'(base + idx), 1'b1);
      if (win_valid) seen++;
      check($sformatf("%s wv px%0d", tag, idx), 72'(win_valid), 72'(exp_wv));
`ifdef KWIN_FRAME_DONE_EN
      check($sformatf("%s fd px%0d", tag, idx), 72'(frame_done), 72'(idx == 15));
`endif
      if (exp_wv && k < 4) begin
        check($sformatf("%s win px%0d", tag, tab[k].pix_idx),
              {p1, p2, p3, p4, p5, p6, p7, p8, p9}, offset_win(tab[k].win, base));
        k++;
      end
      if (gap) begin
        send(8'hAA, 1'b0);
        if (win_valid) seen++;
        check($sformatf("%s idle wv px%0d", tag, idx), 72'(win_valid), 72'(0));
`ifdef KWIN_FRAME_DONE_EN
        check($sformatf("%s idle fd px%0d", tag, idx), 72'(frame_done), 72'(0));
`endif
      end
    end
    check($sformatf("%s win_count", tag), 72'(seen), 72'(4));
  endtask

  initial begin
    tab[0] = '{10, mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10)};
    tab[1] = '{11, mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11)};
    tab[2] = '{14, mkwin(4, 5, 6, 8, 9, 10, 12, 13, 14)};
    tab[3] = '{15, mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15)};

    repeat (2) @(posedge clk);
    #1;
    check("reset wv", 72'(win_valid), 72'(0));
    check("reset window", {p1, p2, p3, p4, p5, p6, p7, p8, p9}, 72'(0));
`ifdef KWIN_FRAME_DONE_EN
    check("reset fd", 72'(frame_done), 72'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    stream_frame(0, 1'b0, "ramp");
    stream_frame(0, 1'b1, "gapped");

    // Mid-frame reset after pixel 9; pixels offered during reset must be dropped.
    for (int idx = 0; idx < 10; idx++) send(8'(idx), 1'b1);
    @(negedge clk);
    rst       = 1'b1;
    pix_in    = 8'd77;
    pix_valid = 1'b1;
    #1;
    check("midrst window", {p1, p2, p3, p4, p5, p6, p7, p8, p9}, 72'(0));
    check("midrst wv", 72'(win_valid), 72'(0));
    repeat (2) @(posedge clk);
    #1;
    check("midrst held window", {p1, p2, p3, p4, p5, p6, p7, p8, p9}, 72'(0));
    @(negedge clk);
    rst       = 1'b0;
    pix_valid = 1'b0;
    stream_frame(0, 1'b0, "postrst");

    stream_frame(0, 1'b0, "b2b_a");
    stream_frame(100, 1'b0, "b2b_b");

    send(8'h00, 1'b0);
    check("tail wv", 72'(win_valid), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
